// File: rtl/tx_resp_scheduler_if.sv
// Response-scheduler bus: ALU/register-file sources, UART TX byte strobe, error flags.
// master = upstream/TX-side driver, slave = tx_resp_scheduler.
interface tx_resp_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
);
  logic [ALU_WIDTH-1:0]  ALU_OUT;
  logic                  ALU_OUT_VALID;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_DATA_VALID;
  logic                  BUSY;
  logic                  CLR_ERR;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic [1:0]            OVERRUN;
  logic                  TIMEOUT_ERR;
  logic                  SCHED_IDLE;

  modport master (
    output ALU_OUT, ALU_OUT_VALID, RD_DATA, RD_DATA_VALID, BUSY, CLR_ERR,
    input  TX_P_DATA, TX_D_VLD, OVERRUN, TIMEOUT_ERR, SCHED_IDLE
  );

  modport slave (
    input  ALU_OUT, ALU_OUT_VALID, RD_DATA, RD_DATA_VALID, BUSY, CLR_ERR,
    output TX_P_DATA, TX_D_VLD, OVERRUN, TIMEOUT_ERR, SCHED_IDLE
  );
endinterface

// File: rtl/tx_resp_scheduler.sv
// Round-robin scheduler of ALU / register-file responses onto the UART TX byte strobe.
// Optional RESP_CHECKSUM_EN appends an XOR checksum byte to every response.
module tx_resp_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int ALU_WIDTH    = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RST,
  tx_resp_scheduler_if.slave  bus
);

  localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

`ifdef RESP_CHECKSUM_EN
  localparam logic [1:0] EXTRA_BYTES = 2'd1;
`else
  localparam logic [1:0] EXTRA_BYTES = 2'd0;
`endif

  logic [1:0]            state_q, state_d;
  logic [ALU_WIDTH-1:0]  alu_slot_q, alu_slot_d;
  logic                  alu_pend_q, alu_pend_d;
  logic [DATA_WIDTH-1:0] rd_slot_q, rd_slot_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  dec_q, dec_d;
  logic                  sel_alu_q, sel_alu_d;
  logic                  last_alu_q, last_alu_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic [1:0]            overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

  logic       finish;
  logic       rel_alu, rel_rd;
  logic [1:0] ovr_evt;
  logic       tmo_evt;
  logic [1:0] last_idx;

  // Byte idx of a response: ALU lo, hi, lo^hi; RD byte and its checksum are the same value.
  function automatic logic [DATA_WIDTH-1:0] resp_byte(
    input logic                  alu,
    input logic [1:0]            idx,
    input logic [ALU_WIDTH-1:0]  a,
    input logic [DATA_WIDTH-1:0] r
  );
    logic [DATA_WIDTH-1:0] lo, hi;
    lo = a[DATA_WIDTH-1:0];
    hi = a[ALU_WIDTH-1:DATA_WIDTH];
    if (alu) begin
      case (idx)
        2'd0:    resp_byte = lo;
        2'd1:    resp_byte = hi;
        default: resp_byte = lo ^ hi;
      endcase
    end else begin
      resp_byte = r;
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    alu_slot_d = alu_slot_q;
    alu_pend_d = alu_pend_q;
    rd_slot_d  = rd_slot_q;
    rd_pend_d  = rd_pend_q;
    dec_d      = dec_q;
    sel_alu_d  = sel_alu_q;
    last_alu_d = last_alu_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = 1'b0;
    finish     = 1'b0;
    rel_alu    = 1'b0;
    rel_rd     = 1'b0;
    ovr_evt    = 2'b00;
    tmo_evt    = 1'b0;
    last_idx   = (sel_alu_q ? 2'd1 : 2'd0) + EXTRA_BYTES;

    case (state_q)
      S_IDLE: begin
        // First pending cycle registers the source choice; the next one launches byte 0.
        if (dec_q) begin
          dec_d      = 1'b0;
          byte_idx_d = 2'd0;
          tx_data_d  = resp_byte(sel_alu_q, 2'd0, alu_slot_q, rd_slot_q);
          tx_vld_d   = 1'b1;
          state_d    = S_SEND;
        end else if (alu_pend_q || rd_pend_q) begin
          dec_d     = 1'b1;
          sel_alu_d = alu_pend_q && (!rd_pend_q || !last_alu_q);
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.BUSY) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          tmo_evt = 1'b1;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.BUSY) finish = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      if (byte_idx_q != last_idx) begin
        byte_idx_d = byte_idx_q + 2'd1;
        tx_data_d  = resp_byte(sel_alu_q, byte_idx_q + 2'd1, alu_slot_q, rd_slot_q);
        tx_vld_d   = 1'b1;
        state_d    = S_SEND;
      end else begin
        rel_alu    = sel_alu_q;
        rel_rd     = !sel_alu_q;
        last_alu_d = sel_alu_q;
        state_d    = S_IDLE;
      end
    end

    // A slot released on this edge counts as empty for a strobe arriving on the same edge.
    if (bus.ALU_OUT_VALID) begin
      if (alu_pend_q && !rel_alu) begin
        ovr_evt[1] = 1'b1;
      end else begin
        alu_slot_d = bus.ALU_OUT;
        alu_pend_d = 1'b1;
      end
    end else if (rel_alu) begin
      alu_pend_d = 1'b0;
    end

    if (bus.RD_DATA_VALID) begin
      if (rd_pend_q && !rel_rd) begin
        ovr_evt[0] = 1'b1;
      end else begin
        rd_slot_d = bus.RD_DATA;
        rd_pend_d = 1'b1;
      end
    end else if (rel_rd) begin
      rd_pend_d = 1'b0;
    end

    overrun_d = (bus.CLR_ERR ? 2'b00 : overrun_q) | ovr_evt;
    timeout_d = (bus.CLR_ERR ? 1'b0 : timeout_q) | tmo_evt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      alu_slot_q <= '0;
      alu_pend_q <= 1'b0;
      rd_slot_q  <= '0;
      rd_pend_q  <= 1'b0;
      dec_q      <= 1'b0;
      sel_alu_q  <= 1'b0;
      last_alu_q <= 1'b0;
      byte_idx_q <= 2'd0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      overrun_q  <= 2'b00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_slot_q <= alu_slot_d;
      alu_pend_q <= alu_pend_d;
      rd_slot_q  <= rd_slot_d;
      rd_pend_q  <= rd_pend_d;
      dec_q      <= dec_d;
      sel_alu_q  <= sel_alu_d;
      last_alu_q <= last_alu_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.TX_P_DATA   = tx_data_q;
  assign bus.TX_D_VLD    = tx_vld_q;
  assign bus.OVERRUN     = overrun_q;
  assign bus.TIMEOUT_ERR = timeout_q;
  assign bus.SCHED_IDLE  = (state_q == S_IDLE) && !alu_pend_q && !rd_pend_q;

endmodule

// File: tb/tb_tx_resp_scheduler.sv
// Bench for tx_resp_scheduler: byte scoreboard, vector table, and hand-written corner sequences.
module tb_tx_resp_scheduler;

  logic clk;
  logic rst_n;
  bit   busy_en;

  tx_resp_scheduler_if #(.DATA_WIDTH(8), .ALU_WIDTH(16)) bus ();

  tx_resp_scheduler #(.DATA_WIDTH(8), .ALU_WIDTH(16), .BUSY_TIMEOUT(64)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  bit prev_vld = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        is_alu;
    logic [15:0] val;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input logic [7:0] b);
    exp_q.push_back(b);
`ifdef RESP_CHECKSUM_EN
    exp_q.push_back(b);
`endif
  endtask

  task automatic exp_alu(input logic [7:0] lo, input logic [7:0] hi);
    exp_q.push_back(lo);
    exp_q.push_back(hi);
`ifdef RESP_CHECKSUM_EN
    exp_q.push_back(lo ^ hi);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 2000; k++) begin
      if (exp_q.size() == 0 && bus.SCHED_IDLE) break;
      cyc();
    end
    check(name, {31'd0, (exp_q.size() == 0 && bus.SCHED_IDLE === 1'b1)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_data"}, {24'd0, bus.TX_P_DATA}, 32'h00);
    check({name, "_vld"}, {31'd0, bus.TX_D_VLD}, 32'd0);
    check({name, "_ovr"}, {30'd0, bus.OVERRUN}, 32'd0);
    check({name, "_tmo"}, {31'd0, bus.TIMEOUT_ERR}, 32'd0);
    check({name, "_idle"}, {31'd0, bus.SCHED_IDLE}, 32'd1);
  endtask

  // Scoreboard monitor: every strobe must match the next expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.TX_D_VLD) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got byte %0h expected no pulse at %0t", bus.TX_P_DATA, $time);
        end else begin
          check("tx_byte", {24'd0, bus.TX_P_DATA}, {24'd0, exp_q.pop_front()});
        end
        check("busy_low_at_pulse", {31'd0, bus.BUSY}, 32'd0);
        check("pulse_width", {31'd0, prev_vld}, 32'd0);
      end
      prev_vld = bus.TX_D_VLD;
    end else begin
      prev_vld = 1'b0;
    end
  end

  // UART model: BUSY rises a few cycles after each strobe and stays high 10 cycles.
  initial begin
    bus.BUSY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_en && bus.TX_D_VLD === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 bus.BUSY = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.BUSY = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 16'h00A5, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 16'h1234, 8'h34, 8'h12};
    vecs[2] = '{1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 16'hFF00, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, 16'h00FF, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 16'h8001, 8'h01, 8'h80};

    busy_en           = 1'b1;
    rst_n             = 1'b0;
    bus.ALU_OUT       = '0;
    bus.ALU_OUT_VALID = 1'b0;
    bus.RD_DATA       = '0;
    bus.RD_DATA_VALID = 1'b0;
    bus.CLR_ERR       = 1'b0;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // Latency: strobe captured at E0, strobe visible after E2.
    bus.RD_DATA = 8'hA5;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'hA5);
    cyc();
    bus.RD_DATA_VALID = 1'b0;
    check("lat_e0_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    check("lat_e0_busy_sched", {31'd0, bus.SCHED_IDLE}, 32'd0);
    cyc();
    check("lat_e1_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    cyc();
    check("lat_e2_vld", {31'd0, bus.TX_D_VLD}, 32'd1);
    check("lat_e2_data", {24'd0, bus.TX_P_DATA}, 32'hA5);
    wait_done("lat_done");

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_alu) begin
        bus.ALU_OUT = vecs[i].val;
        bus.ALU_OUT_VALID = 1'b1;
        exp_alu(vecs[i].b0, vecs[i].b1);
      end else begin
        bus.RD_DATA = vecs[i].val[7:0];
        bus.RD_DATA_VALID = 1'b1;
        exp_rd(vecs[i].b0);
      end
      cyc();
      bus.ALU_OUT_VALID = 1'b0;
      bus.RD_DATA_VALID = 1'b0;
      wait_done("vec_done");
    end

    // Simultaneous strobes from reset: ALU wins the first tie.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.ALU_OUT = 16'hBEEF;
    bus.ALU_OUT_VALID = 1'b1;
    bus.RD_DATA = 8'h5A;
    bus.RD_DATA_VALID = 1'b1;
    exp_alu(8'hEF, 8'hBE);
    exp_rd(8'h5A);
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    bus.RD_DATA_VALID = 1'b0;
    wait_done("tie_first");
    // ALU served last, so the next tie goes to RD.
    bus.ALU_OUT = 16'h1234;
    bus.ALU_OUT_VALID = 1'b1;
    exp_alu(8'h34, 8'h12);
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    wait_done("alu_only");
    bus.ALU_OUT = 16'hCAFE;
    bus.ALU_OUT_VALID = 1'b1;
    bus.RD_DATA = 8'h3C;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'h3C);
    exp_alu(8'hFE, 8'hCA);
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    bus.RD_DATA_VALID = 1'b0;
    wait_done("tie_rr");

    // Overrun on the RD slot, then clear.
    bus.RD_DATA = 8'hA5;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'hA5);
    cyc();
    bus.RD_DATA = 8'h11;
    cyc();
    bus.RD_DATA_VALID = 1'b0;
    check("overrun_set", {30'd0, bus.OVERRUN}, 32'd1);
    wait_done("overrun_done");
    check("overrun_sticky", {30'd0, bus.OVERRUN}, 32'd1);
    bus.CLR_ERR = 1'b1;
    cyc();
    bus.CLR_ERR = 1'b0;
    check("overrun_clr", {30'd0, bus.OVERRUN}, 32'd0);

    // Overrun event in the same cycle as CLR_ERR keeps the flag set.
    bus.RD_DATA = 8'h42;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'h42);
    cyc();
    bus.RD_DATA = 8'h43;
    bus.CLR_ERR = 1'b1;
    cyc();
    bus.RD_DATA_VALID = 1'b0;
    bus.CLR_ERR = 1'b0;
    check("overrun_vs_clr", {30'd0, bus.OVERRUN}, 32'd1);
    wait_done("ovr_clr_done");
    bus.CLR_ERR = 1'b1;
    cyc();
    bus.CLR_ERR = 1'b0;

    // Strobe landing on the release edge is accepted without overrun.
    bus.RD_DATA = 8'h81;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'h81);
    cyc();
    bus.RD_DATA_VALID = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.BUSY) break;
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.BUSY) break;
    end
    bus.RD_DATA = 8'h99;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'h99);
    @(posedge clk);
    #1;
    bus.RD_DATA_VALID = 1'b0;
    check("release_edge_ovr", {30'd0, bus.OVERRUN}, 32'd0);
    wait_done("release_edge_done");

    // Timeout: BUSY never rises.
    busy_en = 1'b0;
    bus.RD_DATA = 8'h77;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'h77);
    cyc();
    bus.RD_DATA_VALID = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.TX_D_VLD) break;
      cyc();
    end
    check("tmo_pulse_seen", {31'd0, bus.TX_D_VLD}, 32'd1);
    repeat (64) cyc();
    check("tmo_before", {31'd0, bus.TIMEOUT_ERR}, 32'd0);
    cyc();
    check("tmo_after", {31'd0, bus.TIMEOUT_ERR}, 32'd1);
    wait_done("tmo_done");
    busy_en = 1'b1;
    bus.RD_DATA = 8'h3C;
    bus.RD_DATA_VALID = 1'b1;
    exp_rd(8'h3C);
    cyc();
    bus.RD_DATA_VALID = 1'b0;
    wait_done("after_tmo_done");
    check("tmo_sticky", {31'd0, bus.TIMEOUT_ERR}, 32'd1);
    bus.CLR_ERR = 1'b1;
    cyc();
    bus.CLR_ERR = 1'b0;
    check("tmo_clr", {31'd0, bus.TIMEOUT_ERR}, 32'd0);

    // Asynchronous reset in WAIT_LO of an ALU response (with ALU overrun pending).
    bus.ALU_OUT = 16'h1234;
    bus.ALU_OUT_VALID = 1'b1;
    exp_alu(8'h34, 8'h12);
    cyc();
    bus.ALU_OUT = 16'h9999;
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    check("alu_overrun", {30'd0, bus.OVERRUN}, 32'd2);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.BUSY) break;
    end
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    begin
      int snap;
      snap = pulse_cnt;
      cyc();
      rst_n = 1'b1;
      repeat (40) cyc();
      check("no_pulse_after_rst", pulse_cnt, snap);
      check("idle_after_rst", {31'd0, bus.SCHED_IDLE}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
